pla_sweep_ctrl: RTL and testbench
=================================

# pla_sweep_ctrl

Sequencer that sweeps a single-output combinational logic cone (a PLA-derived or re-synthesised netlist) over its full input space, one vector per clock. It drives the shared input bus of two cone instances, the golden original and the optimised candidate, and accumulates on-set size and mismatch statistics. It is the on-chip equivalence and characterisation harness for the benchmark cones: it is instantiated around the cones, and its results go to the experiment readout.

## Interface
Parameters:
- `N_IN`, default 12: cone input count; the sweep covers 2^N_IN vectors. Legal range is 1..20.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start_i` in 1: begin a sweep; sampled only in IDLE or DONE.
- `abort_i` in 1: stop the current sweep; sampled only in SWEEP.
- `stop_on_mis_i` in 1: end the sweep at the first mismatch; sampled at start.
- `vec_o` out N_IN: registered input vector driven to both cones.
- `y_ref_i` in 1: golden cone output; combinational from `vec_o`.
- `y_dut_i` in 1: candidate cone output; combinational from `vec_o`.
- `busy_o` out 1: high in SWEEP.
- `done_o` out 1: high in DONE.
- `aborted_o` out 1: the last sweep ended by `abort_i`.
- `onset_cnt_o` out N_IN+1: number of evaluated vectors with `y_ref_i`=1.
- `mis_cnt_o` out N_IN+1: number of evaluated vectors with `y_ref_i`≠`y_dut_i`.
- `first_mis_vld_o` out 1: at least one mismatch seen.
- `first_mis_vec_o` out N_IN: vector of the first mismatch.

## Operation
- FSM states:
  - IDLE: waits for `start_i`.
  - SWEEP: evaluates one vector per cycle.
  - DONE: holds results.
- Transitions:
  - IDLE or DONE, `start_i`=1: go to SWEEP. On the same edge, clear `vec_o`, both counters, `first_mis_vld_o`, `first_mis_vec_o` and `aborted_o`, and latch `stop_on_mis_i`.
  - SWEEP, `abort_i`=1: go to IDLE and set `aborted_o`. The vector present in that cycle is still counted. Counters hold their values.
  - SWEEP, last vector (`vec_o`=2^N_IN−1), or latched stop-on-mismatch with a mismatch this cycle: go to DONE. The current vector is counted.
  - SWEEP, otherwise: `vec_o` increments by 1.
  - DONE: holds all outputs until `start_i`.
- Evaluation: every cycle in SWEEP samples `y_ref_i` and `y_dut_i` for the current `vec_o` and updates the counters. Counters are N_IN+1 bits wide, so the full-onset value 2^N_IN fits without wrap.
- First mismatch: captured only while `first_mis_vld_o`=0; later mismatches never overwrite it.
- Priority: `abort_i` takes precedence over last-vector and stop-on-mismatch in the same cycle. The final vector is still counted, and the block goes to IDLE with `aborted_o`=1.
- `start_i` is ignored in SWEEP. `abort_i` is ignored outside SWEEP.
- Reset values: state IDLE, `vec_o`=0, all counts 0, `busy_o`, `done_o`, `aborted_o` and `first_mis_vld_o` all 0, `first_mis_vec_o`=0. A reset mid-sweep discards all results.

## Timing
- `start_i` at edge k: SWEEP from k+1, evaluating vector 0 in cycle k+1.
- A full sweep is exactly 2^N_IN SWEEP cycles. With N_IN=12 that is 4096 cycles.
- `done_o` rises one cycle after the last vector is evaluated.
- Counters are updated at the edge that ends each evaluation cycle, so counts are final when `done_o` rises.
- Cone path: `vec_o` register → cone logic → sample register, all within one clock period. No multicycle path.
- `vec_o` holds its last value in DONE and IDLE.

## Structure
- Shared package `pla_sweep_pkg` contains:
  - state enum `sweep_state_t` (IDLE, SWEEP, DONE);
  - width helper constant `CNT_W(N)` = N+1.
- One sub-module, `sat_counter`: a parameterised-width counter with clear and increment enable, used for the onset and mismatch counts. Its saturation is never reached at the chosen width; saturation exists as a safety net only.
- Cone instances live outside this block. The bench connects two copies, or one copy plus an injected fault.

## Test plan
1. Identical cones, reference 12-input cone, full sweep → `done_o` after 4096 busy cycles; `mis_cnt_o`=0; `first_mis_vld_o`=0; `onset_cnt_o` equals the bench model's on-set count.
2. Candidate is the golden cone XOR (`vec_o`==12'h5A3), `stop_on_mis_i`=0 → `mis_cnt_o`=1, `first_mis_vec_o`=12'h5A3, sweep still runs all 4096 vectors.
3. Candidate is the golden cone XOR (vec[0]), `stop_on_mis_i`=1 → DONE after 2 SWEEP cycles; `first_mis_vec_o`=1; `mis_cnt_o`=1.
4. `abort_i` pulsed at the 100th SWEEP cycle → next state IDLE; `aborted_o`=1; `done_o`=0; counts cover vectors 0..99. A later `start_i` clears everything and a full sweep completes.
5. `abort_i` asserted in the cycle evaluating 12'hFFF → IDLE with `aborted_o`=1, counts include 12'hFFF. Separately, `start_i` held for the whole sweep → no restart until DONE.
6. `rst_n` low for 1 cycle mid-sweep at vector 2000 → all outputs return to their reset values on the next edge; IDLE; `start_i` is then needed to resume.

Source files
------------

// File: rtl/pla_sweep_pkg.sv
// Shared types and width helpers for the cone sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pla_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } sweep_state_t;

   // Counters need one extra bit so a full on-set (2^N) fits without wrapping.
   function automatic int CNT_W(input int n);
      return n + 1;
   endfunction

endpackage

// File: rtl/pla_sweep_ctrl_sat_counter.sv
// Parameterised up-counter with synchronous clear and increment enable; sticks at all-ones.
// Latency: count visible one cycle after the increment/clear request.
// Backpressure: none; increment requests at saturation are dropped.
module sat_counter #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear wins over increment; saturation is a safety net only.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pla_sweep_ctrl.sv
// Sweeps a single-output cone pair over all 2^N_IN inputs, counting on-set size and mismatches.
// Latency: vector 0 is evaluated the cycle after start; done rises one cycle after the last vector.
// Backpressure: none; one vector per clock, abort ends the sweep early and returns to IDLE.
module pla_sweep_ctrl
   import pla_sweep_pkg::*;
#(
   parameter int N_IN = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic                   stop_on_mis_i,
   output logic [N_IN-1:0]        vec_o,
   input  logic                   y_ref_i,
   input  logic                   y_dut_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   aborted_o,
   output logic [CNT_W(N_IN)-1:0] onset_cnt_o,
   output logic [CNT_W(N_IN)-1:0] mis_cnt_o,
   output logic                   first_mis_vld_o,
   output logic [N_IN-1:0]        first_mis_vec_o
);

   localparam int              CW       = CNT_W(N_IN);
   localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

   sweep_state_t    state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic            stop_q, stop_d;
   logic            aborted_q, aborted_d;
   logic            fmv_q, fmv_d;
   logic [N_IN-1:0] fmvec_q, fmvec_d;

   logic            cnt_clr;
   logic            inc_on;
   logic            inc_mis;
   logic            mis_now;

   assign mis_now = y_ref_i ^ y_dut_i;

   // Next-state and datapath control; every SWEEP cycle counts its vector, even the aborting one.
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      stop_d    = stop_q;
      aborted_d = aborted_q;
      fmv_d     = fmv_q;
      fmvec_d   = fmvec_q;
      cnt_clr   = 1'b0;
      inc_on    = 1'b0;
      inc_mis   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d   = SWEEP;
               vec_d     = '0;
               stop_d    = stop_on_mis_i;
               aborted_d = 1'b0;
               fmv_d     = 1'b0;
               fmvec_d   = '0;
               cnt_clr   = 1'b1;
            end
         end
         SWEEP: begin
            inc_on  = y_ref_i;
            inc_mis = mis_now;
            if (mis_now && !fmv_q) begin
               fmv_d   = 1'b1;
               fmvec_d = vec_q;
            end
            if (abort_i) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if ((vec_q == VEC_LAST) || (stop_q && mis_now)) begin
               state_d = DONE;
            end else begin
               vec_d = vec_q + N_IN'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and result registers; reset discards any sweep in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         stop_q    <= 1'b0;
         aborted_q <= 1'b0;
         fmv_q     <= 1'b0;
         fmvec_q   <= '0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         stop_q    <= stop_d;
         aborted_q <= aborted_d;
         fmv_q     <= fmv_d;
         fmvec_q   <= fmvec_d;
      end
   end

   sat_counter #(.W(CW)) u_onset_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .inc_i (inc_on),
      .cnt_o (onset_cnt_o)
   );

   sat_counter #(.W(CW)) u_mis_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .inc_i (inc_mis),
      .cnt_o (mis_cnt_o)
   );

   assign vec_o           = vec_q;
   assign busy_o          = (state_q == SWEEP);
   assign done_o          = (state_q == DONE);
   assign aborted_o       = aborted_q;
   assign first_mis_vld_o = fmv_q;
   assign first_mis_vec_o = fmvec_q;

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Bench for the cone sweep sequencer: golden cone plus fault-injected candidate, reference model of results.
// Latency: n/a.
// Backpressure: n/a.
module tb_pla_sweep_ctrl;

   localparam int N  = 12;
   localparam int NV = 1 << N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic          stop_on_mis_i = 1'b0;
   logic [N-1:0]  vec_o;
   logic          y_ref_i;
   logic          y_dut_i;
   logic          busy_o;
   logic          done_o;
   logic          aborted_o;
   logic [N:0]    onset_cnt_o;
   logic [N:0]    mis_cnt_o;
   logic          first_mis_vld_o;
   logic [N-1:0]  first_mis_vec_o;

   logic [NV-1:0] flt = '0;

   int n_vec = 0;
   int n_mis = 0;

   // current fault-set statistics (prefix sums over vectors below index)
   int on_pre [0:NV];
   int mi_pre [0:NV];
   int fm_idx;

   // model snapshot taken at each start
   bit m_run = 1'b0;
   int m_t   = 0;
   int m_L   = 0;
   bit m_ab  = 1'b0;
   int m_fm  = -1;
   int m_on [0:NV];
   int m_mi [0:NV];
   int ab_at = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   // Reference cone: on-set is 5/8 of the space (2560 of 4096).
   function automatic logic golden(input logic [N-1:0] v);
      return (v[0] & v[1]) | (v[11] ^ v[5]);
   endfunction

   assign y_ref_i = golden(vec_o);
   assign y_dut_i = golden(vec_o) ^ flt[vec_o];

   pla_sweep_ctrl #(.N_IN(N)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_i         (start_i),
      .abort_i         (abort_i),
      .stop_on_mis_i   (stop_on_mis_i),
      .vec_o           (vec_o),
      .y_ref_i         (y_ref_i),
      .y_dut_i         (y_dut_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .aborted_o       (aborted_o),
      .onset_cnt_o     (onset_cnt_o),
      .mis_cnt_o       (mis_cnt_o),
      .first_mis_vld_o (first_mis_vld_o),
      .first_mis_vec_o (first_mis_vec_o)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   task automatic build();
      on_pre[0] = 0;
      mi_pre[0] = 0;
      fm_idx    = -1;
      for (int i = 0; i < NV; i++) begin
         on_pre[i+1] = on_pre[i] + int'(golden(N'(i)));
         mi_pre[i+1] = mi_pre[i] + int'(flt[i]);
         if (flt[i] && fm_idx < 0) fm_idx = i;
      end
   endtask

   // Model: at a start, the sweep length follows from the earliest of abort, stop-on-mismatch and the last vector.
   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_run = 1'b0;
            m_t   = 0;
         end else if (start_i && (!m_run || m_t > m_L)) begin
            int l0;
            l0 = NV;
            if (stop_on_mis_i && fm_idx >= 0) l0 = fm_idx + 1;
            if (ab_at >= 1 && ab_at <= l0) begin
               m_L  = ab_at;
               m_ab = 1'b1;
            end else begin
               m_L  = l0;
               m_ab = 1'b0;
            end
            m_fm = fm_idx;
            for (int i = 0; i <= NV; i++) begin
               m_on[i] = on_pre[i];
               m_mi[i] = mi_pre[i];
            end
            m_run = 1'b1;
            m_t   = 1;
         end else if (m_run && m_t <= m_L) begin
            m_t++;
         end
      end
   end

   // Abort pulse lands in the ab_at-th sweep cycle of the current run.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         abort_i = (ab_at > 0) && m_run && (m_t == ab_at);
      end
   end

   // Per-cycle compare of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            int  e;
            bit  eb, ed, ea, efv;
            int  ev, efm;
            if (!m_run) begin
               e = 0; eb = 0; ed = 0; ea = 0; ev = 0;
            end else if (m_t <= m_L) begin
               e = m_t - 1; eb = 1; ed = 0; ea = 0; ev = m_t - 1;
            end else begin
               e = m_L; eb = 0; ed = !m_ab; ea = m_ab; ev = m_L - 1;
            end
            efv = m_run && (m_fm >= 0) && (m_fm < e);
            efm = efv ? m_fm : 0;
            chk("busy",     busy_o,          eb);
            chk("done",     done_o,          ed);
            chk("aborted",  aborted_o,       ea);
            chk("vec",      vec_o,           ev);
            chk("onset",    onset_cnt_o,     m_run ? m_on[e] : 0);
            chk("mis",      mis_cnt_o,       m_run ? m_mi[e] : 0);
            chk("fmis_vld", first_mis_vld_o, efv);
            chk("fmis_vec", first_mis_vec_o, efm);
         end
      end
   end

   // Called #1 after a rising edge; returns with outputs settled #1 after the edge following the sweep end.
   task automatic run(input bit stop, input int abort_at, output int nbusy);
      build();
      ab_at         = abort_at;
      stop_on_mis_i = stop;
      start_i       = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!busy_o) break;
         nbusy++;
      end
      chk("sweep_ends", busy_o, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nb;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_on = 1'b1;
      chk("rst_vec", vec_o, 0);
      chk("rst_busy", busy_o, 0);

      // 1: identical cones, full sweep
      flt = '0;
      run(1'b0, 0, nb);
      chk("t1_busy_cycles", nb, 4096);
      chk("t1_done", done_o, 1);
      chk("t1_mis", mis_cnt_o, 0);
      chk("t1_fmv", first_mis_vld_o, 0);
      chk("t1_onset", onset_cnt_o, 2560);

      // 2: single-vector fault, no stop
      flt = '0;
      flt[12'h5A3] = 1'b1;
      run(1'b0, 0, nb);
      chk("t2_busy_cycles", nb, 4096);
      chk("t2_mis", mis_cnt_o, 1);
      chk("t2_fmvec", first_mis_vec_o, 12'h5A3);
      chk("t2_fmv", first_mis_vld_o, 1);

      // 3: fault on every odd vector, stop at first mismatch
      for (int i = 0; i < NV; i++) flt[i] = i[0];
      run(1'b1, 0, nb);
      chk("t3_busy_cycles", nb, 2);
      chk("t3_done", done_o, 1);
      chk("t3_fmvec", first_mis_vec_o, 1);
      chk("t3_mis", mis_cnt_o, 1);
      chk("t3_onset", onset_cnt_o, 0);

      // 4: abort in the 100th sweep cycle, then a clean full sweep
      flt = '0;
      run(1'b0, 100, nb);
      chk("t4_busy_cycles", nb, 100);
      chk("t4_aborted", aborted_o, 1);
      chk("t4_done", done_o, 0);
      chk("t4_onset", onset_cnt_o, 52);
      chk("t4_vec", vec_o, 99);
      run(1'b0, 0, nb);
      chk("t4b_aborted", aborted_o, 0);
      chk("t4b_onset", onset_cnt_o, 2560);

      // 5: abort on the last vector; then start held across a whole sweep
      run(1'b0, 4096, nb);
      chk("t5_aborted", aborted_o, 1);
      chk("t5_done", done_o, 0);
      chk("t5_vec", vec_o, 12'hFFF);
      chk("t5_onset", onset_cnt_o, 2560);
      build();
      ab_at   = 0;
      start_i = 1'b1;
      repeat (4097) @(posedge clk);
      #1 start_i = 1'b0;
      chk("t5b_done", done_o, 1);
      chk("t5b_vec", vec_o, 12'hFFF);
      @(posedge clk);
      #1;

      // 6: reset pulse while vector 2000 is being evaluated
      build();
      ab_at   = 0;
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (2000) @(posedge clk);
      #1;
      chk("t6_pre_vec", vec_o, 2000);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("t6_busy", busy_o, 0);
      chk("t6_vec", vec_o, 0);
      chk("t6_onset", onset_cnt_o, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t6_idle_busy", busy_o, 0);
      run(1'b0, 0, nb);
      chk("t6b_busy_cycles", nb, 4096);

      // randomized fault sets, stop mode and abort points
      for (int r = 0; r < 6; r++) begin
         int nf;
         flt = '0;
         nf  = $urandom_range(0, 4);
         for (int k = 0; k < nf; k++) flt[$urandom_range(0, NV - 1)] = 1'b1;
         run(1'b1 & $urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4200) : 0, nb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
